// File: rtl/current_switch_sequencer.sv
// Thermometer-code sequencer for current_switch_array: slews the switch count one unit
// per dwell period toward a requested target, settles, then pulses done.
module current_switch_sequencer #(
  parameter int N_ARRAY       = 47,
  parameter int CW            = $clog2(N_ARRAY + 1),
  parameter int DWELL_CYCLES  = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int RESET_CODE    = N_ARRAY
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [CW-1:0]      i_target,
  input  logic               i_target_valid,
  output logic               o_target_ready,
  input  logic               i_abort,
  output logic [N_ARRAY-1:0] o_ctrl,
  output logic [CW-1:0]      o_code,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // One counter serves both the dwell and settle phases, so size it for the longer one.
  localparam int CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES + 1) ? DWELL_CYCLES : SETTLE_CYCLES + 1;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]   CODE_MAX    = CW'(N_ARRAY);
  localparam logic [CNTW-1:0] DWELL_LAST  = CNTW'(DWELL_CYCLES - 1);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYCLES);

  function automatic logic [N_ARRAY-1:0] therm(input logic [CW-1:0] c);
    logic [N_ARRAY-1:0] t;
    t = '0;
    for (int i = 0; i < N_ARRAY; i++) begin
      t[i] = (i < int'(c));
    end
    return t;
  endfunction

  localparam logic [N_ARRAY-1:0] RESET_CTRL = therm(CW'(RESET_CODE));

  state_t             r_state;
  logic [CW-1:0]      r_code;
  logic [CW-1:0]      r_target;
  logic [CNTW-1:0]    r_cnt;
  logic [N_ARRAY-1:0] r_ctrl;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;

  state_t             w_state_nxt;
  logic [CW-1:0]      w_code_nxt;
  logic [CW-1:0]      w_target_nxt;
  logic [CNTW-1:0]    w_cnt_nxt;
  logic               w_done_nxt;
  logic [CW-1:0]      w_clamped;
  logic [CW-1:0]      w_step_code;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_code   <= CW'(RESET_CODE);
      r_target <= CW'(RESET_CODE);
      r_cnt    <= '0;
      r_ctrl   <= RESET_CTRL;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_target <= w_target_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ctrl   <= therm(w_code_nxt);
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= w_done_nxt;
      r_ready  <= (w_state_nxt == IDLE);
    end
  end

  // Abort freezes the code where it stands; it only matters once a move is under way.
  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = 1'b0;
    w_clamped    = (i_target > CODE_MAX) ? CODE_MAX : i_target;
    w_step_code  = (r_code < r_target) ? (r_code + CW'(1)) : (r_code - CW'(1));

    if (i_abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_target_valid) begin
            w_target_nxt = w_clamped;
            w_cnt_nxt    = '0;
            if (w_clamped != r_code) begin
              w_state_nxt = RAMP;
            end else begin
              w_done_nxt = 1'b1;
            end
          end
        end
        RAMP: begin
          if (r_cnt == DWELL_LAST) begin
            w_code_nxt = w_step_code;
            w_cnt_nxt  = '0;
            if (w_step_code == r_target) begin
              w_state_nxt = SETTLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNTW'(1);
          end
        end
        SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNTW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_ctrl         = r_ctrl;
  assign o_code         = r_code;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_target_ready = r_ready;

endmodule

// File: tb/tb_current_switch_sequencer.sv
// Bench for current_switch_sequencer: vector table of moves with a latency scoreboard,
// plus hand-written abort and asynchronous-reset sequences.
module tb_current_switch_sequencer;

  localparam int N      = 47;
  localparam int CW     = 6;
  localparam int DWELL  = 10;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rstN;
  logic [CW-1:0] target;
  logic          targetValid;
  logic          targetReady;
  logic          abortReq;
  logic [N-1:0]  ctrl;
  logic [CW-1:0] code;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prevCode = 0;
  bit havePrev = 1'b0;

  typedef struct {
    logic [CW-1:0] target;
    logic [CW-1:0] expCode;
    int            expLatency;
    bit            expRamp;
    bit            midPulse;
  } vec_t;

  typedef struct {
    logic [CW-1:0] code;
    int            latency;
  } exp_t;

  vec_t vecs[7];
  exp_t sbQ[$];

  current_switch_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_target       (target),
    .i_target_valid (targetValid),
    .o_target_ready (targetReady),
    .i_abort        (abortReq),
    .o_ctrl         (ctrl),
    .o_code         (code),
    .o_busy         (busy),
    .o_done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] thermo(input int c);
    logic [N-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) t[i] = (i < c);
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Every wait goes through here so the ctrl decode and single-step rules are watched continuously.
  task automatic tick();
    int c;
    int diff;
    @(negedge clk);
    if (rstN) begin
      c = int'(code);
      checkOutput("ctrlDecode", 64'(ctrl), 64'(thermo(c)));
      checkOutput("codeInRange", 64'(c <= N), 64'd1);
      if (havePrev) begin
        diff = (c > prevCode) ? c - prevCode : prevCode - c;
        checkOutput("codeStep", 64'(diff <= 1), 64'd1);
      end
      prevCode = c;
      havePrev = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [CW-1:0] t, output int acc);
    tick();
    target      = t;
    targetValid = 1'b1;
    @(posedge clk);
    #1;
    acc         = cyc;
    targetValid = 1'b0;
  endtask

  task automatic waitDone(input int acc, input bit expRamp, input bit midPulse);
    int   lastCode;
    int   lat;
    int   n;
    bit   seen;
    exp_t e;
    lastCode = int'(code);
    lat      = -1;
    n        = 0;
    seen     = 1'b0;
    while (!seen && n < BUDGET) begin
      tick();
      n++;
      targetValid = 1'b0;
      if (int'(code) != lastCode) begin
        checkOutput("stepTiming", 64'((cyc - acc) % DWELL), 64'd0);
        lastCode = int'(code);
      end
      if (done) begin
        seen = 1'b1;
        lat  = cyc - acc;
      end else begin
        checkOutput("busyWhileMoving", 64'(busy), 64'(expRamp));
        checkOutput("readyWhileMoving", 64'(targetReady), 64'(!expRamp));
        if (midPulse && (cyc - acc == 100)) begin
          target      = 6'd5;
          targetValid = 1'b1;
        end
      end
    end
    e = sbQ.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: no done within %0d cycles, expected code %0d", BUDGET, e.code);
    end else begin
      checkOutput("doneLatency", 64'(lat), 64'(e.latency));
      checkOutput("finalCode", 64'(code), 64'(e.code));
      checkOutput("finalCtrl", 64'(ctrl), 64'(thermo(int'(e.code))));
      checkOutput("busyAtDone", 64'(busy), 64'd0);
      checkOutput("readyAtDone", 64'(targetReady), 64'd1);
      tick();
      checkOutput("doneOnePulse", 64'(done), 64'd0);
    end
  endtask

  initial begin
    int acc;
    bit sawDone;

    rstN        = 1'b0;
    target      = '0;
    targetValid = 1'b0;
    abortReq    = 1'b0;

    vecs[0] = '{6'd63, 6'd47, 0,   1'b0, 1'b0};
    vecs[1] = '{6'd0,  6'd0,  487, 1'b1, 1'b0};
    vecs[2] = '{6'd63, 6'd47, 487, 1'b1, 1'b1};
    vecs[3] = '{6'd20, 6'd20, 287, 1'b1, 1'b0};
    vecs[4] = '{6'd20, 6'd20, 0,   1'b0, 1'b0};
    vecs[5] = '{6'd21, 6'd21, 27,  1'b1, 1'b0};
    vecs[6] = '{6'd20, 6'd20, 27,  1'b1, 1'b0};

    #12;
    checkOutput("resetCode", 64'(code), 64'd47);
    checkOutput("resetCtrl", 64'(ctrl), 64'h7FFF_FFFF_FFFF);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetReady", 64'(targetReady), 64'd1);
    checkOutput("resetDone", 64'(done), 64'd0);
    tick();
    rstN = 1'b1;

    // Table-driven moves; each accepted request pushes its expected completion.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].target, acc);
      sbQ.push_back('{vecs[i].expCode, vecs[i].expLatency});
      waitDone(acc, vecs[i].expRamp, vecs[i].midPulse);
    end

    // Abort partway through a ramp down from the reset code.
    tick();
    rstN     = 1'b0;
    havePrev = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    checkOutput("reResetCode", 64'(code), 64'd47);
    applyStimulus(6'd0, acc);
    while (cyc - acc < 54) tick();
    abortReq = 1'b1;
    tick();
    abortReq = 1'b0;
    checkOutput("abortCode", 64'(code), 64'd42);
    checkOutput("abortReady", 64'(targetReady), 64'd1);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    sawDone = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    checkOutput("abortNoDone", 64'(sawDone), 64'd0);
    checkOutput("abortHold", 64'(code), 64'd42);
    applyStimulus(6'd45, acc);
    sbQ.push_back('{6'd45, 47});
    waitDone(acc, 1'b1, 1'b0);

    // Asynchronous reset between clock edges while ramping down through code 30.
    applyStimulus(6'd0, acc);
    while ((int'(code) != 30) && (cyc - acc < 400)) tick();
    checkOutput("reachedCode30", 64'(code), 64'd30);
    #1;
    rstN     = 1'b0;
    havePrev = 1'b0;
    #2;
    checkOutput("asyncResetCode", 64'(code), 64'd47);
    checkOutput("asyncResetCtrl", 64'(ctrl), 64'h7FFF_FFFF_FFFF);
    checkOutput("asyncResetBusy", 64'(busy), 64'd0);
    checkOutput("asyncResetReady", 64'(targetReady), 64'd1);
    tick();
    rstN = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    checkOutput("postResetCode", 64'(code), 64'd47);
    checkOutput("postResetReady", 64'(targetReady), 64'd1);
    checkOutput("postResetBusy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
